trace_collector: RTL and testbench



---
 rtl/trace_collector_pkg.sv | 20 ++
 rtl/trace_collector_if.sv | 10 +
 rtl/trace_collector_popcount.sv | 17 +
 rtl/trace_collector.sv | 135 +++++++++++++
 tb/tb_trace_collector.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_collector_pkg.sv
// Shared types and size helpers for the trace collector: FSM state encoding
// and word-count derivations for the header and payload sections of a frame.
package trace_collector_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, HDR, PAY, HD} state_t;

  function automatic int hdr_words(int sim_w, int word_w);
    return sim_w / word_w;
  endfunction

  function automatic int pay_words(int out_size, int word_w);
    return (out_size + word_w - 1) / word_w;
  endfunction

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int cnt_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trace_collector_if.sv
// Word stream carrying trace frames out of the collector (valid/ready).
interface trace_collector_if #(parameter int WORD_W = 8);
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [WORD_W-1:0] m_data;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/trace_collector_popcount.sv
// Combinational population count; used for the Hamming-distance word of a frame.
module trace_collector_popcount #(
  parameter  int W  = 20,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/trace_collector.sv
// Captures dut_out CYCLES edges after start and streams {sim_cnt, capture[, HD]}.
// Define TRACE_COLLECTOR_HD_EN to append a Hamming-distance word to each frame.
module trace_collector
  import trace_collector_pkg::*;
#(
  parameter int OUT_SIZE = 20,
  parameter int CYCLES   = 4,
  parameter int WORD_W   = 8,
  parameter int SIM_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OUT_SIZE-1:0] dut_out,
  trace_collector_if.master   stream,
  output logic                busy,
  output logic [SIM_W-1:0]    sim_cnt,
  output logic                overrun
);

  localparam int HDR_WORDS = hdr_words(SIM_W, WORD_W);
  localparam int PAY_WORDS = pay_words(OUT_SIZE, WORD_W);
`ifdef TRACE_COLLECTOR_HD_EN
  localparam int HD_WORDS = 1;
`else
  localparam int HD_WORDS = 0;
`endif
  localparam int TOTAL_WORDS = HDR_WORDS + PAY_WORDS + HD_WORDS;
  localparam int IDX_W       = cnt_w(TOTAL_WORDS);
  localparam int WAIT_W      = cnt_w(CYCLES);
  localparam int PAY_BITS    = PAY_WORDS * WORD_W;

  state_t              state;
  state_t              next_seg;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [OUT_SIZE-1:0] cap;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    next_idx;
  logic [PAY_BITS-1:0] cap_pad;
  logic [WORD_W-1:0]   words [TOTAL_WORDS];

`ifdef TRACE_COLLECTOR_HD_EN
  localparam int POP_W = $clog2(OUT_SIZE + 1);
  logic [OUT_SIZE-1:0] prev;
  logic [POP_W-1:0]    pop_cnt;

  trace_collector_popcount #(.W(OUT_SIZE)) u_popcount (
    .bits  (cap ^ prev),
    .count (pop_cnt)
  );
`endif

  assign busy = (state != IDLE);

  // Whole frame laid out as a flat word list; the FSM only walks an index.
  always_comb begin
    cap_pad  = PAY_BITS'(cap);
    next_idx = idx + IDX_W'(1);
    for (int h = 0; h < HDR_WORDS; h++) begin
      words[h] = sim_cnt[h*WORD_W +: WORD_W];
    end
    for (int p = 0; p < PAY_WORDS; p++) begin
      words[HDR_WORDS+p] = cap_pad[p*WORD_W +: WORD_W];
    end
`ifdef TRACE_COLLECTOR_HD_EN
    words[TOTAL_WORDS-1] = WORD_W'(pop_cnt);
`endif
    if (next_idx < IDX_W'(HDR_WORDS)) begin
      next_seg = HDR;
    end else if (next_idx < IDX_W'(HDR_WORDS + PAY_WORDS)) begin
      next_seg = PAY;
    end else begin
      next_seg = HD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cap            <= '0;
      idx            <= '0;
      sim_cnt        <= '0;
      overrun        <= 1'b0;
      stream.m_valid <= 1'b0;
      stream.m_data  <= '0;
      stream.m_last  <= 1'b0;
`ifdef TRACE_COLLECTOR_HD_EN
      prev           <= '0;
`endif
    end else begin
      overrun <= overrun | (start & busy);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_W'(CYCLES - 1)) begin
            cap            <= dut_out;
            state          <= HDR;
            idx            <= '0;
            stream.m_valid <= 1'b1;
            stream.m_data  <= words[0];
            stream.m_last  <= 1'b0;
          end
        end
        default: begin
          // Next word is loaded on the transfer edge so a ready sink sees no bubbles.
          if (stream.m_valid && stream.m_ready) begin
            if (stream.m_last) begin
              state          <= IDLE;
              stream.m_valid <= 1'b0;
              stream.m_last  <= 1'b0;
              stream.m_data  <= '0;
              sim_cnt        <= sim_cnt + 1'b1;
`ifdef TRACE_COLLECTOR_HD_EN
              prev           <= cap;
`endif
            end else begin
              idx           <= next_idx;
              state         <= next_seg;
              stream.m_data <= words[next_idx];
              stream.m_last <= (next_idx == IDX_W'(TOTAL_WORDS - 1));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_collector.sv
// Directed testbench for trace_collector; exercises the HD word too when
// TRACE_COLLECTOR_HD_EN is defined.
module tb_trace_collector;

`ifdef TRACE_COLLECTOR_HD_EN
  localparam int FRAME_N = 6;
`else
  localparam int FRAME_N = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] dut_out;
  logic        busy;
  logic [15:0] sim_cnt;
  logic        overrun;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [7:0]  got_data [16];
  logic        got_last [16];
  int          got_cyc  [16];
  int          got_n;
  int          stall_seen;
  int          stall_bad;
  logic [3:0]  bp_pat = 4'b1001;

  trace_collector_if #(.WORD_W(8)) stream ();

  trace_collector #(
    .OUT_SIZE (20),
    .CYCLES   (4),
    .WORD_W   (8),
    .SIM_W    (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dut_out (dut_out),
    .stream  (stream),
    .busy    (busy),
    .sim_cnt (sim_cnt),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Collects every transfer over a fixed window and notes any stall where the word changed.
  task automatic run_capture(input int ncycles, input bit bp);
    bit         prev_stall;
    logic [7:0] held_d;
    logic       held_l;
    got_n      = 0;
    stall_seen = 0;
    stall_bad  = 0;
    prev_stall = 1'b0;
    held_d     = '0;
    held_l     = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      stream.m_ready = bp ? bp_pat[c % 4] : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        stall_seen++;
        if (!stream.m_valid || stream.m_data !== held_d || stream.m_last !== held_l)
          stall_bad++;
      end
      if (stream.m_valid && stream.m_ready && got_n < 16) begin
        got_data[got_n] = stream.m_data;
        got_last[got_n] = stream.m_last;
        got_cyc[got_n]  = c;
        got_n++;
      end
      prev_stall = stream.m_valid && !stream.m_ready;
      held_d     = stream.m_data;
      held_l     = stream.m_last;
      @(posedge clk);
      #1;
    end
    stream.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    start          = 1'b0;
    dut_out        = '0;
    stream.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", stream.m_valid); end
    n_checks++; if (stream.m_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got %h want 00", stream.m_data); end
    n_checks++; if (stream.m_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last got %b want 0", stream.m_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (sim_cnt !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_sim_cnt got %h want 0000", sim_cnt); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp [5];
    exp = '{8'h00, 8'h00, 8'h3F, 8'h5C, 8'h0A};
    stream.m_ready = 1'b1;
    dut_out = 20'hA5C3F;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid got %b want 0", stream.m_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_wait_busy got %b want 1", busy); end
    @(posedge clk);
    #1;
    n_checks++; if (stream.m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_capture_valid got %b want 1", stream.m_valid); end
    run_capture(10, 1'b0);
    n_checks++; if (got_n !== FRAME_N) begin n_fail++; $display("[TB] FAIL basic_count got %0d want %0d", got_n, FRAME_N); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("[TB] FAIL basic_word%0d got %h want %h", i, got_data[i], exp[i]); end
    end
    for (int i = 0; i < FRAME_N; i++) begin
      n_checks++; if (got_last[i] !== (i == FRAME_N - 1)) begin n_fail++; $display("[TB] FAIL basic_last%0d got %b want %b", i, got_last[i], (i == FRAME_N - 1)); end
    end
    n_checks++; if (got_cyc[FRAME_N-1] - got_cyc[0] !== FRAME_N - 1) begin n_fail++; $display("[TB] FAIL back_to_back_span got %0d want %0d", got_cyc[FRAME_N-1] - got_cyc[0], FRAME_N - 1); end
    n_checks++; if (sim_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL basic_sim_cnt got %0d want 1", sim_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_idle got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [5];
    exp = '{8'h01, 8'h00, 8'h3F, 8'h5C, 8'h0A};
    dut_out = 20'hA5C3F;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    run_capture(24, 1'b1);
    n_checks++; if (got_n !== FRAME_N) begin n_fail++; $display("[TB] FAIL bp_count got %0d want %0d", got_n, FRAME_N); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("[TB] FAIL bp_word%0d got %h want %h", i, got_data[i], exp[i]); end
    end
    n_checks++; if (got_last[FRAME_N-1] !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_last got %b want 1", got_last[FRAME_N-1]); end
    n_checks++; if (stall_bad !== 0 || stall_seen == 0) begin n_fail++; $display("[TB] FAIL bp_hold got %0d changed of %0d stalls want 0 changed", stall_bad, stall_seen); end
    n_checks++; if (sim_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL bp_sim_cnt got %0d want 2", sim_cnt); end
  endtask

  task automatic test_capture_timing();
    logic [7:0] exp [5];
    exp = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h00};
    dut_out = 20'h00001;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 dut_out = 20'h00002;
    @(posedge clk);
    #1 dut_out = 20'h00003;
    run_capture(10, 1'b0);
    n_checks++; if (got_n !== FRAME_N) begin n_fail++; $display("[TB] FAIL timing_count got %0d want %0d", got_n, FRAME_N); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("[TB] FAIL timing_word%0d got %h want %h", i, got_data[i], exp[i]); end
    end
    n_checks++; if (sim_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL timing_sim_cnt got %0d want 3", sim_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [5];
    exp = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
    do_reset();
    dut_out = 20'h00003;
    pulse_start();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_set got %b want 1", overrun); end
    @(posedge clk);
    #1;
    run_capture(20, 1'b0);
    n_checks++; if (got_n !== FRAME_N) begin n_fail++; $display("[TB] FAIL overrun_frames got %0d words want %0d", got_n, FRAME_N); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("[TB] FAIL overrun_word%0d got %h want %h", i, got_data[i], exp[i]); end
    end
    n_checks++; if (sim_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL overrun_sim_cnt got %0d want 1", sim_cnt); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] exp [5];
    exp = '{8'hFF, 8'hFF, 8'h45, 8'h23, 8'h01};
    do_reset();
    force dut.sim_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.sim_cnt;
    @(posedge clk);
    #1;
    n_checks++; if (sim_cnt !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL wrap_preload got %h want ffff", sim_cnt); end
    dut_out = 20'h12345;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    run_capture(10, 1'b0);
    n_checks++; if (got_n !== FRAME_N) begin n_fail++; $display("[TB] FAIL wrap_count got %0d want %0d", got_n, FRAME_N); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (got_data[i] !== exp[i]) begin n_fail++; $display("[TB] FAIL wrap_word%0d got %h want %h", i, got_data[i], exp[i]); end
    end
    n_checks++; if (sim_cnt !== 16'h0000) begin n_fail++; $display("[TB] FAIL wrap_sim_cnt got %h want 0000", sim_cnt); end

    // Second frame: provoke an overrun, then reset while payload words are streaming.
    pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (stream.m_valid !== 1'b1 || busy !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL midpay_state got v%b b%b o%b want v1 b1 o1", stream.m_valid, busy, overrun); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midpay_valid got %b want 0", stream.m_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midpay_busy got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL midpay_overrun got %b want 0", overrun); end
    run_capture(6, 1'b0);
    n_checks++; if (got_n !== 0) begin n_fail++; $display("[TB] FAIL midpay_resume got %0d words want 0", got_n); end
  endtask

`ifdef TRACE_COLLECTOR_HD_EN
  task automatic test_hd();
    do_reset();
    dut_out = 20'h0000F;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    run_capture(12, 1'b0);
    n_checks++; if (got_n !== 6) begin n_fail++; $display("[TB] FAIL hd1_count got %0d want 6", got_n); end
    n_checks++; if (got_data[5] !== 8'h04) begin n_fail++; $display("[TB] FAIL hd1_word got %h want 04", got_data[5]); end
    n_checks++; if (got_last[5] !== 1'b1 || got_last[4] !== 1'b0) begin n_fail++; $display("[TB] FAIL hd1_last got %b%b want 10", got_last[5], got_last[4]); end
    dut_out = 20'h000F0;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    run_capture(12, 1'b0);
    n_checks++; if (got_data[2] !== 8'hF0) begin n_fail++; $display("[TB] FAIL hd2_payload got %h want f0", got_data[2]); end
    n_checks++; if (got_data[5] !== 8'h08) begin n_fail++; $display("[TB] FAIL hd2_word got %h want 08", got_data[5]); end
    n_checks++; if (got_last[5] !== 1'b1) begin n_fail++; $display("[TB] FAIL hd2_last got %b want 1", got_last[5]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_capture_timing();
    test_overrun();
    test_wrap_and_reset();
`ifdef TRACE_COLLECTOR_HD_EN
    test_hd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
